// File: rtl/bus_arb.sv
// Registered shared datapath bus: drives one WIDTH-bit bus from NSRC sources,
// either by a direct select or by round-robin arbitration with request/grant and lock.
module bus_arb #(
    parameter  int WIDTH = 16,
    parameter  int NSRC  = 8,
    localparam int SEL_W = (NSRC > 2) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arb_mode,
    input  logic                  sel_en,
    input  logic [SEL_W-1:0]      read_sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_req,
    input  logic                  lock,
    output logic [NSRC-1:0]       src_gnt,
    output logic [WIDTH-1:0]      busout,
    output logic                  bus_valid,
    output logic [SEL_W-1:0]      bus_src,
    output logic                  bus_err
);

    localparam logic [SEL_W:0]    NSRC_X   = (SEL_W+1)'(NSRC);
    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NSRC - 1);
    localparam logic [NSRC-1:0]   GNT_ONE  = NSRC'(1);

    logic [WIDTH-1:0] w_src [NSRC];

    logic [WIDTH-1:0] r_bus;
    logic [SEL_W-1:0] r_src;
    logic             r_valid;
    logic [NSRC-1:0]  r_gnt;
    logic             r_err;
    logic [SEL_W-1:0] r_ptr;

    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W:0]   w_scan;
    logic             w_hold;
    logic             w_take;
    logic [SEL_W-1:0] w_g;

    logic [WIDTH-1:0] w_nxt_bus;
    logic [SEL_W-1:0] w_nxt_src;
    logic             w_nxt_valid;
    logic [NSRC-1:0]  w_nxt_gnt;
    logic             w_nxt_err;
    logic [SEL_W-1:0] w_nxt_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin scan: first requester at or after r_ptr, wrapping at NSRC.
    // The ptr+k sum stays below 2*NSRC, so one conditional subtract is a full modulo.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan     = '0;
        for (int k = 0; k < NSRC; k++) begin
            w_scan     = {1'b0, r_ptr} + (SEL_W+1)'(k);
            w_scan     = (w_scan >= NSRC_X) ? (w_scan - NSRC_X) : w_scan;
            w_rr_idx   = (!w_rr_found && src_req[w_scan[SEL_W-1:0]]) ? w_scan[SEL_W-1:0] : w_rr_idx;
            w_rr_found = w_rr_found | src_req[w_scan[SEL_W-1:0]];
        end
    end

    // Lock keeps the current owner only while it is still on the bus and requesting.
    assign w_hold = lock & r_valid & src_req[r_src];

    // Next-state selection for both modes.
    always_comb begin
        w_nxt_bus   = r_bus;
        w_nxt_src   = r_src;
        w_nxt_valid = 1'b0;
        w_nxt_gnt   = '0;
        w_nxt_err   = 1'b0;
        w_nxt_ptr   = r_ptr;
        w_take      = 1'b0;
        w_g         = '0;
        if (arb_mode) begin
            if (w_hold) begin
                w_take = 1'b1;
                w_g    = r_src;
            end else if (w_rr_found) begin
                w_take    = 1'b1;
                w_g       = w_rr_idx;
                w_nxt_ptr = (w_rr_idx == LAST_IDX) ? '0 : (w_rr_idx + SEL_W'(1));
            end else begin
                w_take = 1'b0;
            end
        end else begin
            if (sel_en && ({1'b0, read_sel} < NSRC_X)) begin
                w_take = 1'b1;
                w_g    = read_sel;
            end else if (sel_en) begin
                w_nxt_bus = '0;
                w_nxt_err = 1'b1;
            end else begin
                w_take = 1'b0;
            end
        end
        if (w_take) begin
            w_nxt_bus   = w_src[w_g];
            w_nxt_src   = w_g;
            w_nxt_valid = 1'b1;
            w_nxt_gnt   = GNT_ONE << w_g;
        end else begin
            w_nxt_valid = 1'b0;
        end
    end

    // Output and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus   <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_bus   <= w_nxt_bus;
            r_src   <= w_nxt_src;
            r_valid <= w_nxt_valid;
            r_gnt   <= w_nxt_gnt;
            r_err   <= w_nxt_err;
            r_ptr   <= w_nxt_ptr;
        end
    end

    assign busout    = r_bus;
    assign bus_src   = r_src;
    assign bus_valid = r_valid;
    assign src_gnt   = r_gnt;
    assign bus_err   = r_err;

endmodule

// File: doc/bus_arb.md
# bus_arb

Parametrised, registered shared datapath bus that replaces the fixed 8-source combinational bus multiplexer. It drives one WIDTH-bit bus from NSRC source registers (R, DR, TR, PC, AC, DM, IM, …). Two modes are supported: direct select (a control-unit-driven select, as in the legacy bus) and round-robin arbitration with per-source request/grant and bus lock. It sits between the datapath registers and their consumers, and adds one cycle of latency in exchange for a clean registered bus.

## Interface
- WIDTH, 16, bus and source data width; narrower registers (8-bit PC/DR/DM/IM) are zero-extended at instantiation.
- NSRC, 8, number of sources; legal range 2..16.
- SEL_W, derived localparam max(1, clog2(NSRC)); not overridable.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- arb_mode  in  1  0 = direct select, 1 = round-robin arbitration
- sel_en  in  1  direct mode: bus read request this cycle
- read_sel  in  SEL_W  direct mode: source index
- src_data  in  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
- src_req  in  NSRC  arbitration mode: per-source request
- lock  in  1  arbitration mode: current owner keeps the bus while it still requests
- src_gnt  out  NSRC  one-hot grant, registered
- busout  out  WIDTH  registered bus value
- bus_valid  out  1  busout carries data captured on the last edge
- bus_src  out  SEL_W  index of the source captured into busout
- bus_err  out  1  one-cycle pulse on an out-of-range direct select

## Operation
- Reset (rst_n=0 at an edge): busout=0, bus_valid=0, src_gnt=0, bus_src=0, bus_err=0, round-robin pointer ptr=0. Reset dominates all other inputs and may be applied mid-transfer.
- Direct mode (arb_mode=0):
  - sel_en=1 with read_sel<NSRC: busout<=src_data[read_sel], bus_src<=read_sel, bus_valid<=1, src_gnt<=one-hot(read_sel).
  - sel_en=1 with read_sel>=NSRC: busout<=0, bus_valid<=0, src_gnt<=0, bus_err<=1 for one cycle.
  - sel_en=0: bus_valid<=0, src_gnt<=0, busout and bus_src hold.
  - src_req and lock are ignored; ptr is unchanged.
- Arbitration mode (arb_mode=1), evaluated at each edge:
  - Hold: if lock=1, bus_valid=1, and src_req[bus_src]=1, the grant stays with g=bus_src and ptr is unchanged.
  - Otherwise g is the first i with src_req[i]=1, scanning ptr, ptr+1, … modulo NSRC; then ptr<=(g+1) mod NSRC.
  - On a grant: busout<=src_data[g], bus_src<=g, src_gnt<=one-hot(g), bus_valid<=1.
  - No request: bus_valid<=0, src_gnt<=0, busout/bus_src hold, ptr unchanged.
  - sel_en and read_sel are ignored; bus_err stays 0.
- Mode switch: takes effect at the next edge; ptr is preserved across modes.
- Arithmetic: index comparisons are at SEL_W bits; the ptr wrap from NSRC-1 goes to 0, including non-power-of-2 NSRC.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on busout/bus_valid/src_gnt/bus_src after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Requester handshake: a source sees src_gnt[i]=1 in the same cycle busout holds its data. It may drop src_req the next cycle, and the grant is released at the following edge.
- Under lock with a continuous request, busout re-samples the owner's src_data every cycle (streaming).
- The bus_err pulse lasts exactly one cycle per offending edge. Back-to-back bad selects keep it high.

## Test plan
- Reset: drive rst_n=0 with all sources=16'hFFFF and sel_en=1 -> after the edge busout=0, bus_valid=0, src_gnt=0, bus_err=0; outputs stay there while rst_n=0.
- Direct select: source i=16'h0100+i, sel_en=1, read_sel=3 -> next cycle busout=16'h0103, bus_src=3, src_gnt=8'b0000_1000, bus_valid=1; then sel_en=0 -> bus_valid=0, busout holds 16'h0103.
- Out-of-range: NSRC=6, read_sel=7, sel_en=1 -> busout=0, bus_valid=0, bus_err=1 for one cycle only.
- Round-robin fairness: arb_mode=1, src_req=8'hFF held for 10 cycles from reset -> bus_src sequence 0,1,…,7,0,1; src_gnt is one-hot every cycle.
- Lock: src_req=8'b0010_0100, lock=1 -> first grant goes to 2 and is held while src_req[2]=1, with busout tracking src_data[2] changes; drop src_req[2] -> next grant goes to 5.
- Mode switch and reset mid-run: grant 4 in arbitration mode, then switch to direct with read_sel=1, then back to arbitration with all requests -> direct gives bus_src=1; the next arbitration grant is 5 (ptr preserved). Assert rst_n=0 during any grant -> all outputs 0 and the next arbitration grant goes to 0.
